// File: rtl/g1_table_writer.sv
// g1_table_writer: inserts one rule per request into a G1 bucket chain; optional in-place overwrite of a matching ruleID when G1_WRITER_DUP_CHECK_EN is defined
module g1_table_writer #(
    parameter int SUBSET_NUM       = 0,
    parameter int TABLE_NUM        = 0,
    parameter int TABLE_ENTRY_SIZE = 154,
    parameter int BUCKET_NUM       = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [10:0]  head_index,
    input  logic [10:0]  rule_id,
    input  logic [31:0]  src_ip,
    input  logic [31:0]  dst_ip,
    input  logic [15:0]  src_port_lo,
    input  logic [15:0]  src_port_hi,
    input  logic [15:0]  dst_port_lo,
    input  logic [15:0]  dst_port_hi,
    input  logic [7:0]   protocol,
    input  logic         proto_wild,
    output logic [10:0]  mem_addr,
    output logic         mem_we,
    output logic [170:0] mem_din,
    input  logic [170:0] mem_dout,
    output logic         done,
    output logic [1:0]   status,
    output logic [10:0]  wr_index,
    output logic [10:0]  free_count
);
    localparam logic [11:0] TES      = 12'(TABLE_ENTRY_SIZE);
    localparam logic [11:0] BKT      = 12'(BUCKET_NUM);
    localparam logic [10:0] NULL_IDX = 11'h7FF;
    if (TABLE_ENTRY_SIZE > 2047 || BUCKET_NUM >= TABLE_ENTRY_SIZE || SUBSET_NUM < 0 || TABLE_NUM < 0) begin : g_bad_params
        $error("g1_table_writer: illegal parameters");
    end
    typedef enum logic [2:0] {IDLE, READ, CHECK, WRITE_NEW, LINK, DONE} state_t;
    state_t state, state_nx;
    logic [10:0]  cur, target, tail_addr, new_next, free_cnt;
    logic [11:0]  hops, free_ptr;
    logic [159:0] req_lo, tail_lo;
    logic [1:0]   status_r;
    logic         alloc;
    logic [10:0]  nx;
    logic         valid_hit, dup_hit, tail_hit, full, corrupt;
    assign nx        = mem_dout[170:160];
    assign valid_hit = mem_dout[75];
`ifdef G1_WRITER_DUP_CHECK_EN
    assign dup_hit   = valid_hit && mem_dout[159:149] == req_lo[159:149];
`else
    assign dup_hit   = 1'b0;
`endif
    assign tail_hit  = nx == NULL_IDX;
    assign full      = free_ptr == TES;
    assign corrupt   = {1'b0, nx} >= TES || {1'b0, nx} < BKT || hops == TES;
    // next-state: walk the chain, then write the new entry before linking it
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (req_valid) state_nx = {1'b0, head_index} >= BKT ? DONE : READ;
            READ:      state_nx = CHECK;
            CHECK:     state_nx = !valid_hit || dup_hit ? WRITE_NEW : tail_hit ? (full ? DONE : WRITE_NEW) : corrupt ? DONE : READ;
            WRITE_NEW: state_nx = alloc ? LINK : DONE;
            LINK:      state_nx = DONE;
            DONE:      state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end
    // state register and datapath; reset drops any half-linked insert and refills the pool pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cur       <= '0;
            hops      <= '0;
            target    <= '0;
            tail_addr <= '0;
            tail_lo   <= '0;
            req_lo    <= '0;
            new_next  <= NULL_IDX;
            alloc     <= 1'b0;
            status_r  <= 2'd0;
            free_ptr  <= BKT;
            free_cnt  <= 11'(TABLE_ENTRY_SIZE - BUCKET_NUM);
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (req_valid) begin
                    req_lo   <= {rule_id, proto_wild, protocol, dst_port_lo, dst_port_hi, src_port_lo, src_port_hi, 1'b1, 5'b0, dst_ip, 6'b0, src_ip};
                    cur      <= head_index;
                    hops     <= '0;
                    target   <= '0;
                    alloc    <= 1'b0;
                    new_next <= NULL_IDX;
                    status_r <= {1'b0, head_index} >= BKT ? 2'd3 : 2'd0;
                end
                CHECK: if (!valid_hit) begin
                    target <= cur;
                end else if (dup_hit) begin
                    target   <= cur;
                    new_next <= nx;
                end else if (tail_hit) begin
                    tail_lo   <= mem_dout[159:0];
                    tail_addr <= cur;
                    alloc     <= !full;
                    target    <= full ? 11'd0 : free_ptr[10:0];
                    status_r  <= full ? 2'd1 : 2'd0;
                end else if (corrupt) begin
                    status_r <= 2'd2;
                end else begin
                    cur  <= nx;
                    hops <= hops + 12'd1;
                end
                WRITE_NEW: if (alloc) begin
                    free_ptr <= free_ptr + 12'd1;
                    free_cnt <= free_cnt - 11'd1;
                end
                default: ;
            endcase
        end
    end
    // RAM port and handshake outputs decoded from the current state; rst blocks any write in flight
    always_comb begin
        req_ready  = state == IDLE;
        mem_we     = (state == WRITE_NEW || state == LINK) && !rst;
        mem_addr   = state == READ ? cur : state == WRITE_NEW ? target : state == LINK ? tail_addr : 11'd0;
        mem_din    = state == WRITE_NEW ? {new_next, req_lo} : state == LINK ? {target, tail_lo} : 171'd0;
        done       = state == DONE;
        status     = done ? status_r : 2'd0;
        wr_index   = done ? target : 11'd0;
        free_count = free_cnt;
    end
endmodule

// File: tb/tb_g1_table_writer.sv
// tb_g1_table_writer: directed checks of g1_table_writer against a bench-owned synchronous RAM
module tb_g1_table_writer;
    localparam logic [10:0] NL = 11'h7FF;
    logic         clk = 1'b0;
    logic         rst, req_valid, req_ready, proto_wild, mem_we, done;
    logic [10:0]  head_index, rule_id, mem_addr, wr_index, free_count;
    logic [31:0]  src_ip, dst_ip;
    logic [15:0]  src_port_lo, src_port_hi, dst_port_lo, dst_port_hi;
    logic [7:0]   protocol;
    logic [170:0] mem_din, mem_dout;
    logic [1:0]   status;
    logic [170:0] ram [0:2047];
    logic         pre_we, pre_clr;
    logic [10:0]  pre_addr;
    logic [170:0] pre_din;
    int           checks = 0, errors = 0;
    int           nwr, done_cyc;
    int           w_cyc [4];
    logic [10:0]  w_addr [4];
    logic [170:0] w_din [4];
    logic [1:0]   d_status;
    logic [10:0]  d_idx;
    bit           seen;

    always #5 clk = ~clk;

    g1_table_writer dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .head_index(head_index), .rule_id(rule_id), .src_ip(src_ip), .dst_ip(dst_ip),
        .src_port_lo(src_port_lo), .src_port_hi(src_port_hi),
        .dst_port_lo(dst_port_lo), .dst_port_hi(dst_port_hi),
        .protocol(protocol), .proto_wild(proto_wild),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout),
        .done(done), .status(status), .wr_index(wr_index), .free_count(free_count)
    );

    // table RAM: one-cycle read latency, bench preload port has priority over the DUT
    always @(posedge clk) begin
        if (pre_clr) for (int i = 0; i < 2048; i++) ram[i] <= '0;
        else if (pre_we) ram[pre_addr] <= pre_din;
        else if (mem_we) ram[mem_addr] <= mem_din;
        mem_dout <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic [170:0] got, input logic [170:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [170:0] ent(input logic [10:0] nx, input logic [10:0] rule, input logic [7:0] pr);
        logic [170:0] e;
        e = '0;
        e[170:160] = nx;
        e[159:149] = rule;
        e[148]     = rule[0];
        e[147:140] = pr;
        e[139:124] = 16'd80;
        e[123:108] = 16'd443;
        e[107:92]  = {5'b0, rule};
        e[91:76]   = {5'b0, rule} + 16'd100;
        e[75]      = 1'b1;
        e[69:38]   = 32'h0A00_0000 + {21'b0, rule};
        e[31:0]    = 32'hC0A8_0000 | {21'b0, rule};
        return e;
    endfunction

    task automatic preset(input logic [10:0] a, input logic [170:0] d);
        @(negedge clk);
        pre_addr = a; pre_din = d; pre_we = 1'b1;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic clear_ram();
        @(negedge clk);
        pre_clr = 1'b1;
        @(negedge clk);
        pre_clr = 1'b0;
    endtask

    task automatic drive_req(input logic [10:0] head, input logic [10:0] rule, input logic [7:0] pr);
        @(negedge clk);
        head_index  = head;
        rule_id     = rule;
        proto_wild  = rule[0];
        protocol    = pr;
        dst_port_lo = 16'd80;
        dst_port_hi = 16'd443;
        src_port_lo = {5'b0, rule};
        src_port_hi = {5'b0, rule} + 16'd100;
        src_ip      = 32'hC0A8_0000 | {21'b0, rule};
        dst_ip      = 32'h0A00_0000 + {21'b0, rule};
        req_valid   = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic do_req(input logic [10:0] head, input logic [10:0] rule, input logic [7:0] pr);
        drive_req(head, rule, pr);
        nwr = 0; seen = 1'b0; done_cyc = 0;
        for (int c = 1; c <= 400 && !seen; c++) begin
            @(negedge clk);
            if (mem_we) begin
                if (nwr < 4) begin
                    w_addr[nwr] = mem_addr; w_din[nwr] = mem_din; w_cyc[nwr] = c;
                end
                nwr++;
            end
            if (done) begin
                seen = 1'b1; done_cyc = c; d_status = status; d_idx = wr_index;
            end
        end
        if (!seen) check("done_timeout", 0, 1);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; pre_we = 1'b0; pre_clr = 1'b0; pre_addr = '0; pre_din = '0;
        head_index = '0; rule_id = '0; src_ip = '0; dst_ip = '0; protocol = '0; proto_wild = 1'b0;
        src_port_lo = '0; src_port_hi = '0; dst_port_lo = '0; dst_port_hi = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", req_ready, 1);
        check("rst_we", mem_we, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_done", done, 0);
        check("rst_status", status, 0);
        check("rst_wr_index", wr_index, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_din", mem_din, 0);
        check("rst_free_count", free_count, 122);
        clear_ram();

        do_req(11'd5, 11'd7, 8'd6);
        check("empty_done_cyc", done_cyc, 4);
        check("empty_status", d_status, 0);
        check("empty_wr_index", d_idx, 5);
        check("empty_nwr", nwr, 1);
        check("empty_w_cyc", w_cyc[0], 3);
        check("empty_w_addr", w_addr[0], 5);
        check("empty_w_din", w_din[0], ent(NL, 11'd7, 8'd6));
        check("empty_free", free_count, 122);

        do_req(11'd5, 11'd9, 8'd6);
        check("app_done_cyc", done_cyc, 5);
        check("app_status", d_status, 0);
        check("app_wr_index", d_idx, 32);
        check("app_nwr", nwr, 2);
        check("app_new_cyc", w_cyc[0], 3);
        check("app_new_addr", w_addr[0], 32);
        check("app_new_din", w_din[0], ent(NL, 11'd9, 8'd6));
        check("app_link_cyc", w_cyc[1], 4);
        check("app_link_addr", w_addr[1], 5);
        check("app_link_din", w_din[1], ent(11'd32, 11'd7, 8'd6));
        check("app_free", free_count, 121);

        do_req(11'd5, 11'd9, 8'd17);
`ifdef G1_WRITER_DUP_CHECK_EN
        check("dup_done_cyc", done_cyc, 6);
        check("dup_wr_index", d_idx, 32);
        check("dup_nwr", nwr, 1);
        check("dup_w_cyc", w_cyc[0], 5);
        check("dup_w_addr", w_addr[0], 32);
        check("dup_w_din", w_din[0], ent(NL, 11'd9, 8'd17));
        check("dup_free", free_count, 121);
`else
        check("dup_done_cyc", done_cyc, 7);
        check("dup_wr_index", d_idx, 33);
        check("dup_nwr", nwr, 2);
        check("dup_new_addr", w_addr[0], 33);
        check("dup_new_din", w_din[0], ent(NL, 11'd9, 8'd17));
        check("dup_link_addr", w_addr[1], 32);
        check("dup_link_din", w_din[1], ent(11'd33, 11'd9, 8'd6));
        check("dup_free", free_count, 120);
`endif
        check("dup_status", d_status, 0);

        do_req(11'd40, 11'd1, 8'd6);
        check("bad_done_cyc", done_cyc, 1);
        check("bad_status", d_status, 3);
        check("bad_nwr", nwr, 0);
        check("bad_wr_index", d_idx, 0);

        preset(11'd3, ent(11'd3, 11'd100, 8'd6));
        do_req(11'd3, 11'd50, 8'd6);
        check("loop_status", d_status, 2);
        check("loop_done_cyc", done_cyc, 3);
        check("loop_nwr", nwr, 0);
        check("loop_wr_index", d_idx, 0);
        preset(11'd4, ent(11'd200, 11'd101, 8'd6));
        do_req(11'd4, 11'd51, 8'd6);
        check("range_status", d_status, 2);
        check("range_nwr", nwr, 0);

        preset(11'd6, ent(NL, 11'd61, 8'd6));
        drive_req(11'd6, 11'd62, 8'd6);
        repeat (3) @(negedge clk);
        check("rstmid_new_we", mem_we, 1);
        @(negedge clk);
        check("rstmid_link_addr", mem_addr, 6);
        rst = 1'b1;
        #1 check("rstmid_link_we", mem_we, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstmid_ready", req_ready, 1);
        check("rstmid_done", done, 0);
        check("rstmid_free", free_count, 122);
        check("rstmid_head_kept", ram[6], ent(NL, 11'd61, 8'd6));

        clear_ram();
        for (int i = 0; i < 32; i++) preset(11'(i), ent(NL, 11'(1000 + i), 8'd6));
        for (int k = 0; k < 122; k++) begin
            do_req(11'(k % 32), 11'(200 + k), 8'd6);
            check("fill_status", d_status, 0);
        end
        check("fill_free", free_count, 0);
        do_req(11'd26, 11'd500, 8'd6);
        check("full_status", d_status, 1);
        check("full_nwr", nwr, 0);
        check("full_done_cyc", done_cyc, 9);
        check("full_wr_index", d_idx, 0);
        check("full_free", free_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/g1_table_writer.md
# g1_table_writer

Update-side engine for one G1 rule table: accepts one rule-insert request at a time and writes it into the table RAM's write port. It walks the bucket's singly linked chain to the tail, allocates a free slot, and writes the new entry. It then links the entry into the chain. The search path reads the same RAM concurrently, so write ordering never exposes a dangling `next_index`.

## Interface
Parameters:
- SUBSET_NUM, 0, subset identifier (tagging only)
- TABLE_NUM, 0, table identifier (tagging only)
- TABLE_ENTRY_SIZE, 154, table depth in entries (≤ 2047)
- BUCKET_NUM, 32, entries 0..BUCKET_NUM-1 are bucket heads; BUCKET_NUM..TABLE_ENTRY_SIZE-1 are the free pool

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  insert request
- req_ready  out  1  high only in IDLE
- head_index  in  11  bucket head address
- rule_id  in  11  rule ID
- src_ip, dst_ip  in  32 each  exact-match IPs
- src_port_lo, src_port_hi, dst_port_lo, dst_port_hi  in  16 each  inclusive port ranges
- protocol  in  8  protocol value
- proto_wild  in  1  protocol wildcard
- mem_addr  out  11  RAM address
- mem_we  out  1  RAM write strobe
- mem_din  out  171  RAM write data
- mem_dout  in  171  RAM read data, valid one cycle after mem_addr
- done  out  1  one-cycle completion pulse
- status  out  2  0 ok, 1 table full, 2 chain corrupt, 3 bad head index; valid with done
- wr_index  out  11  slot written; valid with done
- free_count  out  11  remaining free-pool slots

## Operation
- Entry layout: [170:160] next_index (11'h7FF = NULL), [159:149] ruleID, [148] proto_wild, [147:140] protocol, [139:124] dst_port_lo, [123:108] dst_port_hi, [107:92] src_port_lo, [91:76] src_port_hi, [75] valid, [74:70] zero, [69:38] dst_ip, [37:32] zero, [31:0] src_ip.
- States: IDLE, READ, CHECK, WRITE_NEW, LINK, DONE.
- IDLE: req_ready=1. On req_valid, capture all request fields, set cur=head_index and hops=0.
  - head_index ≥ BUCKET_NUM: go to DONE with status 3.
  - Otherwise: go to READ.
- READ: mem_addr=cur, mem_we=0. Go to CHECK.
- CHECK evaluates mem_dout:
  - valid=0 (cur is necessarily a head): target=cur. Go to WRITE_NEW with no allocation.
  - next_index=NULL: save mem_dout as tail_entry and tail_addr=cur.
    - free_ptr == TABLE_ENTRY_SIZE: go to DONE with status 1.
    - Otherwise: target=free_ptr. Go to WRITE_NEW.
  - next_index ≥ TABLE_ENTRY_SIZE, or next_index < BUCKET_NUM, or hops == TABLE_ENTRY_SIZE: go to DONE with status 2.
  - Otherwise: cur=next_index, hops+1. Go to READ.
- WRITE_NEW: mem_we=1, mem_addr=target, mem_din = new entry with valid=1 and next=NULL.
  - If a slot was allocated: free_ptr+1, free_count-1. Go to LINK.
  - Otherwise: go to DONE.
- LINK: mem_we=1, mem_addr=tail_addr, mem_din=tail_entry with [170:160]=target. Go to DONE.
- DONE: done=1, status, wr_index=target (0 on error). Go to IDLE.
- mem_we is 1 only in WRITE_NEW and LINK. The new entry is always written before the link.
- The block never frees slots. RAM must be pre-initialized with valid=0 by its owner.

## Timing
- Reset values:
  - state=IDLE, req_ready=1, done=0, status=0, wr_index=0.
  - mem_we=0, mem_addr=0, mem_din=0.
  - free_ptr=BUCKET_NUM, free_count=TABLE_ENTRY_SIZE-BUCKET_NUM.
- Accept at cycle 0. Each hop costs 2 cycles (READ, CHECK).
- Empty head: WRITE_NEW at cycle 3, done at cycle 4.
- Append to a chain of N≥1 valid entries: WRITE_NEW at 2N+1, LINK at 2N+2, done at 2N+3.
- Bad head: done at cycle 1. Table full: done at 2N+1.
- req_valid outside IDLE is ignored. The request must be held until accepted.
- rst mid-operation: return to IDLE the same edge, no further writes. An entry written but not yet linked is orphaned; free_ptr and free_count reinitialize.

## Configuration
- G1_WRITER_DUP_CHECK_EN defined: in CHECK, an entry with valid=1 and ruleID==rule_id is overwritten in place.
  - The overwrite keeps that entry's next_index; no slot is allocated; status 0; wr_index=that address.
  - Timing for the k-th chain node (k from 1): WRITE_NEW at 2k+1, done at 2k+2.
- Undefined: no ruleID compare; duplicates are appended as new entries.

## Test plan
- Empty head: head_index=5, RAM clear, rule_id=7 → write at addr 5 with valid=1, next=11'h7FF, done at cycle 4, status 0, wr_index 5, free_count unchanged.
- Append: head 5 valid with next=NULL, rule_id=9 → WRITE_NEW addr 32, LINK addr 5 with next=32 and other bits unchanged, done at cycle 5, free_count 121.
- Full pool: insert into occupied heads until free_ptr==154 → next append returns status 1, no writes, free_count 0.
- Corrupt chain: head 3 next=3, then head 4 next=200 → both return status 2 with no writes.
- Bad head: head_index=40 → done at cycle 1, status 3, mem_we never asserted. Additionally, assert rst during LINK → no LINK write, req_ready=1 next cycle.
- With G1_WRITER_DUP_CHECK_EN: re-insert rule_id=9 into the 2-entry chain → overwrite addr 32 keeping next=NULL, done at cycle 6, free_count unchanged. Without the macro, the same request appends at addr 33.
